// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths, zero word and priority pointer encoding
package rf_wb_arbiter_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
    localparam logic PRI_ALU = 1'b0;
    localparam logic PRI_LSU = 1'b1;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: requester handshakes, read addresses and register-file write/forward bundle
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              alu_valid_i;
    logic              alu_ready_o;
    logic [ADDR_W-1:0] alu_addr_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              lsu_valid_i;
    logic              lsu_ready_o;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_data_i;
    logic [ADDR_W-1:0] rd_addr1_i;
    logic [ADDR_W-1:0] rd_addr2_i;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_addr_o;
    logic [DATA_W-1:0] rf_data_o;
    logic              fwd1_o;
    logic              fwd2_o;
    logic [DATA_W-1:0] fwd_data_o;
    logic              busy_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  rd_addr1_i, rd_addr2_i,
        output alu_ready_o, lsu_ready_o, busy_o,
        output rf_we_o, rf_addr_o, rf_data_o,
        output fwd1_o, fwd2_o, fwd_data_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        output rd_addr1_i, rd_addr2_i,
        input  alu_ready_o, lsu_ready_o, busy_o,
        input  rf_we_o, rf_addr_o, rf_data_o,
        input  fwd1_o, fwd2_o, fwd_data_o
    );
endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a single priority pointer
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       busy
);
    logic ptr;

    // a lone requester always wins; under contention the pointer picks
    always_comb begin
        gnt[0] = !rst_i && req[0] && (!req[1] || ptr == PRI_ALU);
        gnt[1] = !rst_i && req[1] && (!req[0] || ptr == PRI_LSU);
        busy   = !rst_i && &req;
    end

    // priority moves to the loser only on contended cycles
    always_ff @(posedge clk_i) ptr <= rst_i ? PRI_ALU : (&req ? ~ptr : ptr);
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU and LSU, with read forwarding
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter bit ZERO_REG_DROP = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    rf_wb_arbiter_if.slave   bus
);
    logic [1:0]        gnt;
    logic              grant;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   ({bus.lsu_valid_i, bus.alu_valid_i}),
        .gnt   (gnt),
        .busy  (bus.busy_o)
    );

    assign bus.alu_ready_o = gnt[0];
    assign bus.lsu_ready_o = gnt[1];

    // select the winning requester's address and data
    always_comb begin
        grant  = |gnt;
        w_addr = gnt[1] ? bus.lsu_addr_i : bus.alu_addr_i;
        w_data = gnt[1] ? bus.lsu_data_i : bus.alu_data_i;
    end

    // write stage plus forwarding aligned with the synchronous register-file read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.rf_we_o    <= 1'b0;
            bus.rf_addr_o  <= '0;
            bus.rf_data_o  <= DATA_W'(ZERO_WORD);
            bus.fwd1_o     <= 1'b0;
            bus.fwd2_o     <= 1'b0;
            bus.fwd_data_o <= DATA_W'(ZERO_WORD);
        end else begin
            bus.rf_we_o    <= grant && !(ZERO_REG_DROP && w_addr == '0);
            bus.rf_addr_o  <= grant ? w_addr : bus.rf_addr_o;
            bus.rf_data_o  <= grant ? w_data : bus.rf_data_o;
            bus.fwd1_o     <= bus.rf_we_o && bus.rf_addr_o == bus.rd_addr1_i;
            bus.fwd2_o     <= bus.rf_we_o && bus.rf_addr_o == bus.rd_addr2_i;
            bus.fwd_data_o <= bus.rf_data_o;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for the writeback arbiter
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        f1;
        logic        f2;
        logic [31:0] fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    logic        m_ptr  = 1'b0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        logic ga, gl;
        rst             = r;
        bus.alu_valid_i = av;
        bus.alu_addr_i  = aa;
        bus.alu_data_i  = ad;
        bus.lsu_valid_i = lv;
        bus.lsu_addr_i  = la;
        bus.lsu_data_i  = ld;
        bus.rd_addr1_i  = r1;
        bus.rd_addr2_i  = r2;
        #1;
        ga = !r && av && (!lv || m_ptr == PRI_ALU);
        gl = !r && lv && (!av || m_ptr == PRI_LSU);
        chk("alu_ready", 64'(bus.alu_ready_o), 64'(ga));
        chk("lsu_ready", 64'(bus.lsu_ready_o), 64'(gl));
        if (!r) chk("busy", 64'(bus.busy_o), 64'(av && lv));
        e.f1 = !r && m_we && m_addr == r1;
        e.f2 = !r && m_we && m_addr == r2;
        e.fd = r ? 32'h0 : m_data;
        if (r) begin
            e.we   = 1'b0;
            e.addr = '0;
            e.data = '0;
            m_ptr  = PRI_ALU;
        end else begin
            e.addr = ga ? aa : (gl ? la : m_addr);
            e.data = ga ? ad : (gl ? ld : m_data);
            e.we   = (ga || gl) && e.addr != 5'd0;
            if (av && lv) m_ptr = ~m_ptr;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rf_we", 64'(bus.rf_we_o), 64'(e.we));
        chk("rf_addr", 64'(bus.rf_addr_o), 64'(e.addr));
        chk("rf_data", 64'(bus.rf_data_o), 64'(e.data));
        chk("fwd1", 64'(bus.fwd1_o), 64'(e.f1));
        chk("fwd2", 64'(bus.fwd2_o), 64'(e.f2));
        chk("fwd_data", 64'(bus.fwd_data_o), 64'(e.fd));
        m_we   = e.we;
        m_addr = e.addr;
        m_data = e.data;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset with both requesters asserting
        step(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 5'd0, 5'd0);
        step(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 5'd0, 5'd0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        // single ALU write
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 5'd1, 5'd2);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd2);
        // sustained contention alternates
        for (int i = 0; i < 4; i++) step(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 5'd1, 5'd2);
        // dropped write to r0
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 5'd3, 5'd3);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        // forwarding to both ports, then only port 1
        step(0, 1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(0, 1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 32'h0, 5'd7, 5'd7);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd8);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd7);
        // mid-stream reset after a contended grant
        step(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, 5'd0, 5'd0);
        step(1, 0, 5'd0, 32'h0, 1, 5'd10, 32'hAA, 5'd9, 5'd9);
        step(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, 5'd0, 5'd0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd0);
        // random traffic
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 15) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
